// File: rtl/vu_level_scheduler_if.sv
// Requester-side bus of the VU level scheduler: one req/ack pair and one
// 8-bit sample slot per meter channel, channel 0 in the top byte.
interface vu_level_scheduler_if #(
  parameter int pack_no = 16
);
  logic [pack_no-1:0]   req;
  logic [pack_no*8-1:0] level_in;
  logic [pack_no-1:0]   ack;

  modport master (output req, output level_in, input ack);
  modport slave  (input req, input level_in, output ack);
endinterface

// File: rtl/vu_level_scheduler.sv
// Round-robin sample collector with shadow registers, vsync-aligned commit
// sweep and per-channel peak-hold with linear decay for the VGA bar renderer.
module vu_level_scheduler #(
  parameter int pack_no     = 16,
  parameter int w           = pack_no * 8,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 v_sync,
  vu_level_scheduler_if.slave  rq,
  output logic [w-1:0]         levels_out,
  output logic [w-1:0]         peak_out,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int IW = (pack_no > 1) ? $clog2(pack_no) : 1;

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [pack_no-1:0]   ack_q, ack_d;
  logic                 vs_q;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [7:0]           shadow_q [pack_no];
  logic [7:0]           shadow_d [pack_no];
  logic [7:0]           levels_q [pack_no];
  logic [7:0]           levels_d [pack_no];
  logic [7:0]           peak_q   [pack_no];
  logic [7:0]           peak_d   [pack_no];
  logic [7:0]           hold_q   [pack_no];
  logic [7:0]           hold_d   [pack_no];

  logic                 tick;
  logic [pack_no-1:0]   eligible;
  logic                 found;
  logic [IW-1:0]        win;
  logic [7:0]           cur_s, cur_p, cur_h, decayed;
  logic [8:0]           dec9;

  assign tick     = vs_q & ~v_sync;
  // A channel still showing ack cannot win again while its requester drops req.
  assign eligible = rq.req & ~ack_q;

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= pack_no; k++) begin
      if (!found && eligible[IW'((int'(ptr_q) + k) % pack_no)]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + k) % pack_no);
      end
    end
  end

  assign cur_s   = shadow_q[idx_q];
  assign cur_p   = peak_q[idx_q];
  assign cur_h   = hold_q[idx_q];
  assign dec9    = {1'b0, cur_p} - 9'(DECAY);
  assign decayed = dec9[8] ? 8'd0 : dec9[7:0];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    ack_d        = '0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    shadow_d     = shadow_q;
    levels_d     = levels_q;
    peak_d       = peak_q;
    hold_d       = hold_q;

    if (found) begin
      ack_d[win]    = 1'b1;
      ptr_d         = win;
      shadow_d[win] = rq.level_in[w-1-8*int'(win) -: 8];
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = UPDATE;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      UPDATE: begin
        // Commit reads shadow_q, so a same-edge arbiter write lands next frame.
        levels_d[idx_q] = cur_s;
        if (cur_s >= cur_p) begin
          peak_d[idx_q] = cur_s;
          hold_d[idx_q] = 8'(HOLD_FRAMES);
        end else if (cur_h != 8'd0) begin
          hold_d[idx_q] = cur_h - 8'd1;
        end else begin
          peak_d[idx_q] = (decayed > cur_s) ? decayed : cur_s;
        end
        if (idx_q == IW'(pack_no - 1)) begin
          state_d      = IDLE;
          idx_d        = '0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ptr_q        <= IW'(pack_no - 1);
      ack_q        <= '0;
      vs_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < pack_no; i++) begin
        shadow_q[i] <= 8'd0;
        levels_q[i] <= 8'd0;
        peak_q[i]   <= 8'd0;
        hold_q[i]   <= 8'd0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      ack_q        <= ack_d;
      vs_q         <= v_sync;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      shadow_q     <= shadow_d;
      levels_q     <= levels_d;
      peak_q       <= peak_d;
      hold_q       <= hold_d;
    end
  end

  assign rq.ack     = ack_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  for (genvar gi = 0; gi < pack_no; gi++) begin : g_pack
    assign levels_out[w-1-8*gi -: 8] = levels_q[gi];
    assign peak_out[w-1-8*gi -: 8]   = peak_q[gi];
  end
endmodule

// File: tb/tb_vu_level_scheduler.sv
// Directed bench for vu_level_scheduler: grant order, vsync commit sweep,
// peak hold/decay, write-during-commit and reset mid-sweep, via a scoreboard.
module tb_vu_level_scheduler;
  localparam int N    = 16;
  localparam int W    = N * 8;
  localparam int HOLD = 2;
  localparam int DEC  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         v_sync;
  logic [W-1:0] levels_out, peak_out;
  logic         busy, frame_done;

  vu_level_scheduler_if #(.pack_no(N)) rq ();

  vu_level_scheduler #(
    .pack_no(N), .w(W), .HOLD_FRAMES(HOLD), .DECAY(DEC)
  ) dut (
    .clk(clk), .rst(rst), .v_sync(v_sync), .rq(rq),
    .levels_out(levels_out), .peak_out(peak_out),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   m_sh [N];
  logic [7:0]   m_lv [N];
  logic [7:0]   m_pk [N];
  int           m_h  [N];
  logic [W-1:0] exp_lv_q [$];
  logic [W-1:0] exp_pk_q [$];
  int           exp_grant_q [$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sl(input logic [W-1:0] v, input int ch);
    return v[W-1-8*ch -: 8];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_sh[c] = 8'd0; m_lv[c] = 8'd0; m_pk[c] = 8'd0; m_h[c] = 0;
    end
  endtask

  // Reference frame update; result pushed to the scoreboard when the sweep starts.
  task automatic model_commit();
    logic [W-1:0] lv, pk;
    int d;
    lv = '0; pk = '0;
    for (int c = 0; c < N; c++) begin
      m_lv[c] = m_sh[c];
      if (m_sh[c] >= m_pk[c]) begin
        m_pk[c] = m_sh[c];
        m_h[c]  = HOLD;
      end else if (m_h[c] > 0) begin
        m_h[c] = m_h[c] - 1;
      end else begin
        d = int'(m_pk[c]) - DEC;
        if (d < 0) d = 0;
        m_pk[c] = (d > int'(m_sh[c])) ? 8'(d) : m_sh[c];
      end
      lv[W-1-8*c -: 8] = m_lv[c];
      pk[W-1-8*c -: 8] = m_pk[c];
    end
    exp_lv_q.push_back(lv);
    exp_pk_q.push_back(pk);
  endtask

  task automatic load(input int ch, input logic [7:0] val);
    logic [W-1:0] onehot;
    bit got;
    got = 1'b0;
    onehot = '0;
    onehot[ch] = 1'b1;
    @(negedge clk);
    rq.level_in[W-1-8*ch -: 8] = val;
    rq.req[ch] = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rq.ack[ch]) got = 1'b1;
    end
    check("load_ack_seen", W'(got), W'(1));
    check("load_ack_onehot", W'(rq.ack), onehot);
    rq.req[ch] = 1'b0;
    m_sh[ch] = val;
    $display("load ch%0d = %02h acked=%0d", ch, val, got);
  endtask

  task automatic run_frame(input int inj_cyc, input int inj_ch, input logic [7:0] inj_val);
    int nb;
    bit done;
    logic [W-1:0] el, ep;
    nb = 0; done = 1'b0;
    @(negedge clk);
    v_sync = 1'b0;
    model_commit();
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      if (inj_cyc >= 0 && rq.ack[inj_ch]) rq.req[inj_ch] = 1'b0;
      if (c == inj_cyc) begin
        rq.level_in[W-1-8*inj_ch -: 8] = inj_val;
        rq.req[inj_ch] = 1'b1;
      end
      if (frame_done) done = 1'b1;
      else if (busy) nb++;
    end
    v_sync = 1'b1;
    check("frame_done_seen", W'(done), W'(1));
    check("busy_len", W'(nb), W'(N));
    el = exp_lv_q.pop_front();
    ep = exp_pk_q.pop_front();
    check("levels", levels_out, el);
    check("peaks", peak_out, ep);
    if (inj_cyc >= 0) m_sh[inj_ch] = inj_val;
    @(negedge clk);
    if (inj_cyc >= 0 && rq.ack[inj_ch]) rq.req[inj_ch] = 1'b0;
    check("frame_done_pulse_len", W'(frame_done), W'(0));
    $display("frame busy=%0d levels=%h peaks=%h", nb, levels_out, peak_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rq.req = '0; rq.level_in = '0; v_sync = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tab0 [6];
    logic [7:0] tab1 [6];
    int seen_fd, seen_ack, seen_busy, g;
    logic [W-1:0] onehot;

    tab0 = '{8'h80, 8'h80, 8'h80, 8'h7C, 8'h78, 8'h74};
    tab1 = '{8'h06, 8'h06, 8'h06, 8'h02, 8'h00, 8'h00};

    rst = 1'b1; v_sync = 1'b1; rq.req = '0; rq.level_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ack", W'(rq.ack), '0);
    check("rst_levels", levels_out, '0);
    check("rst_peaks", peak_out, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_frame_done", W'(frame_done), '0);
    rst = 1'b0;

    // Idle: no requests, no sync edge.
    seen_fd = 0; seen_ack = 0; seen_busy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frame_done) seen_fd++;
      if (rq.ack != '0) seen_ack++;
      if (busy) seen_busy++;
    end
    check("idle_frame_done", W'(seen_fd), '0);
    check("idle_ack", W'(seen_ack), '0);
    check("idle_busy", W'(seen_busy), '0);
    check("idle_levels", levels_out, '0);
    $display("idle 10 cycles fd=%0d ack=%0d busy=%0d", seen_fd, seen_ack, seen_busy);

    // All channels request at once; grants must come 0..15, one per cycle.
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      rq.level_in[W-1-8*c -: 8] = 8'(8'h10 + c);
      m_sh[c] = 8'(8'h10 + c);
      exp_grant_q.push_back(c);
    end
    rq.req = '1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      g = exp_grant_q.pop_front();
      onehot = '0;
      onehot[g] = 1'b1;
      check("rr_grant", W'(rq.ack), onehot);
      $display("grant expected ch%0d ack=%h", g, rq.ack);
      rq.req[g] = 1'b0;
    end
    @(negedge clk);
    check("rr_after_all", W'(rq.ack), '0);

    // Basic commit of two loaded channels.
    load(0, 8'h40);
    load(3, 8'h90);
    run_frame(-1, 0, 8'h00);
    check("ch0_level", W'(sl(levels_out, 0)), W'(8'h40));
    check("ch3_level", W'(sl(levels_out, 3)), W'(8'h90));
    check("ch3_peak", W'(sl(peak_out, 3)), W'(8'h90));

    // ch5 rewritten on the same edge it is committed.
    load(5, 8'h11);
    run_frame(6, 5, 8'h33);
    check("ch5_old_commit", W'(sl(levels_out, 5)), W'(8'h11));
    run_frame(-1, 0, 8'h00);
    check("ch5_new_commit", W'(sl(levels_out, 5)), W'(8'h33));

    // Peak hold then decay, including clamp at zero.
    do_reset();
    load(0, 8'h80);
    load(1, 8'h06);
    for (int f = 0; f < 6; f++) begin
      if (f == 1) begin
        load(0, 8'h00);
        load(1, 8'h00);
      end
      run_frame(-1, 0, 8'h00);
      check("ch0_peak_seq", W'(sl(peak_out, 0)), W'(tab0[f]));
      check("ch1_peak_seq", W'(sl(peak_out, 1)), W'(tab1[f]));
    end

    // Reset in the middle of a sweep.
    load(2, 8'h55);
    @(negedge clk);
    v_sync = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_ch2", W'(sl(levels_out, 2)), W'(8'h55));
    rst = 1'b1; v_sync = 1'b1;
    #1;
    check("midrst_levels", levels_out, '0);
    check("midrst_peaks", peak_out, '0);
    check("midrst_busy", W'(busy), '0);
    check("midrst_ack", W'(rq.ack), '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen_fd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (frame_done) seen_fd++;
    end
    check("post_rst_no_frame_done", W'(seen_fd), '0);
    $display("reset mid-sweep, frame_done after release=%0d", seen_fd);
    load(2, 8'h66);
    run_frame(-1, 0, 8'h00);
    check("post_rst_ch2", W'(sl(levels_out, 2)), W'(8'h66));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
